// File: rtl/lx32_lsu_pkg.sv
// lx32_lsu_pkg -- shared definitions for the LX32 load/store unit:
// RV32I funct3 size/sign encodings, FSM state enum and small decode helpers.
package lx32_lsu_pkg;

   // RV32I load/store funct3 encodings
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Controller states
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RD   = 2'b01,
      WR   = 2'b10,
      RSP  = 2'b11
   } state_e;

   // Access width derived from funct3
   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10
   } size_e;

   // Width of the access; the unused encodings (011, 110, 111) fall into word
   function automatic size_e f3_size(input logic [2:0] f3);
      case (f3)
         F3_B, F3_BU: return SZ_B;
         F3_H, F3_HU: return SZ_H;
         default:     return SZ_W;
      endcase
   endfunction

   // Only LB and LH sign-extend; everything else is zero-extended or full word
   function automatic logic f3_signed(input logic [2:0] f3);
      return (f3 == F3_B) || (f3 == F3_H);
   endfunction

   // True when the address is not naturally aligned for the access width
   function automatic logic lsu_misaligned(input size_e sz, input logic [1:0] addr_lo);
      case (sz)
         SZ_H:    return addr_lo[0];
         SZ_W:    return addr_lo != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lx32_lsu_align.sv
// lx32_lsu_align -- purely combinational lane logic for the LSU.
// Load path: selects the byte/halfword lane of a memory word and extends it.
// Store path: merges the store data into the selected lane of a memory word.
// Lanes come from the low address bits truncated to natural alignment
// (byte: addr[1:0], halfword: addr[1], word: none).
module lx32_lsu_align
   import lx32_lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_data
);

   size_e       size;
   logic        sext;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   assign size = f3_size(funct3);
   assign sext = f3_signed(funct3);

   // Pick the addressed byte and halfword out of the word
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      byte_lane = word[7:0];
      case (addr_lo)
         2'b00:   byte_lane = word[7:0];
         2'b01:   byte_lane = word[15:8];
         2'b10:   byte_lane = word[23:16];
         default: byte_lane = word[31:24];
      endcase
      half_lane = addr_lo[1] ? word[31:16] : word[15:0];
   end

   // Extend the selected lane to 32 bits for the load result
   always_comb begin
      load_data = word;
      case (size)
         SZ_B:    load_data = sext ? {{24{byte_lane[7]}}, byte_lane}
                                   : {24'h000000, byte_lane};
         SZ_H:    load_data = sext ? {{16{half_lane[15]}}, half_lane}
                                   : {16'h0000, half_lane};
         default: load_data = word;
      endcase
   end

   // Replace the selected lane of the word with the low store data bits
   always_comb begin
      store_data = word;
      case (size)
         SZ_B: begin
            case (addr_lo)
               2'b00:   store_data[7:0]   = wdata[7:0];
               2'b01:   store_data[15:8]  = wdata[7:0];
               2'b10:   store_data[23:16] = wdata[7:0];
               default: store_data[31:24] = wdata[7:0];
            endcase
         end
         SZ_H: begin
            if (addr_lo[1]) store_data[31:16] = wdata[15:0];
            else            store_data[15:0]  = wdata[15:0];
         end
         default: store_data = wdata;
      endcase
   end

endmodule

// File: rtl/lx32_lsu.sv
// lx32_lsu -- RV32I load/store unit in front of a word-wide, level-sensitive
// data memory with combinational read data.
//   Load          : IDLE -> RD -> RSP
//   Store word    : IDLE -> WR -> RSP
//   Store byte/half: IDLE -> RD -> WR -> RSP (read-modify-write)
// d_we is decoded straight from the state register so it cannot glitch and
// drops as soon as rst_n is asserted.
// Build option: LX32_LSU_MISALIGN_TRAP_EN -- when defined, misaligned H/W
// accesses skip memory and respond at once with rsp_err=1; when undefined,
// misalignment is ignored and rsp_err is constant 0.
module lx32_lsu
   import lx32_lsu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   // core request
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   // core response
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   // data memory
   output logic [31:0] d_addr,
   output logic [31:0] d_wdata,
   output logic        d_we,
   input  logic [31:0] d_rdata
);

   state_e      state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] word_q, word_d;
   logic        err_q, err_d;

   logic        accept;
   logic        trap;
   logic [31:0] load_data;
   logic [31:0] store_data;

   assign accept = req_valid && (state_q == IDLE);

`ifdef LX32_LSU_MISALIGN_TRAP_EN
   assign trap = lsu_misaligned(f3_size(req_funct3), req_addr[1:0]);
`else
   assign trap = 1'b0;
`endif

   // Lane extraction for loads and lane merge for sub-word stores
   lx32_lsu_align u_align (
      .funct3     (funct3_q),
      .addr_lo    (addr_q[1:0]),
      .word       (word_q),
      .wdata      (wdata_q),
      .load_data  (load_data),
      .store_data (store_data)
   );

   // Next-state and capture logic
   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      word_d   = word_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               we_d     = req_we;
               funct3_d = req_funct3;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               err_d    = trap;
               if (trap)
                  state_d = RSP;
               else if (!req_we)
                  state_d = RD;
               else if (f3_size(req_funct3) == SZ_W)
                  state_d = WR;
               else
                  state_d = RD;
            end
         end
         RD: begin
            word_d  = d_rdata;
            state_d = we_q ? WR : RSP;
         end
         WR: begin
            state_d = RSP;
         end
         RSP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and captured request registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         funct3_q <= 3'b000;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         word_q   <= 32'h0;
         err_q    <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
         state_q  <= state_d;
         we_q     <= we_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         word_q   <= word_d;
         err_q    <= err_d;
      end
   end

   // Memory side: word address and write data come from registers only, so
   // they are stable for the whole WR cycle and read 0 while in reset
   assign d_we    = (state_q == WR);
   assign d_addr  = {addr_q[31:2], 2'b00};
   assign d_wdata = store_data;

   // Core side: response fields are forced to 0 outside RSP
   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RSP);
   assign rsp_err   = (state_q == RSP) && err_q;
   assign rsp_rdata = ((state_q == RSP) && !we_q && !err_q) ? load_data : 32'h0;

endmodule

// File: tb/tb_lx32_lsu.sv
// tb_lx32_lsu -- directed self-checking bench for lx32_lsu with a small
// behavioural word memory (combinational read, write on rising edge while d_we).
// Honours LX32_LSU_MISALIGN_TRAP_EN for the misaligned-word case.
module tb_lx32_lsu;
   import lx32_lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        d_we;

   int n_checks = 0;
   int n_fail   = 0;
   int we_cnt   = 0;

   logic [31:0] mem [0:255];

   always #5 clk = ~clk;

   lx32_lsu dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_we       (d_we),
      .d_rdata    (d_rdata)
   );

   assign d_rdata = mem[d_addr[9:2]];

   // Memory model: preload, then write on each rising edge with d_we high
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[8'h40] = 32'h8899AABB;   // byte address 0x100
      forever begin
         @(posedge clk);
         if (d_we === 1'b1) begin
            mem[d_addr[9:2]] = d_wdata;
            we_cnt++;
         end
      end
   end

   // Global time limit
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one request, return one cycle after the accept edge
   task automatic issue(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
      int waited = 0;
      while (req_ready !== 1'b1 && waited < 20) begin
         step();
         waited++;
      end
      check("issue_ready", 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      step();
      // scramble inputs: the LSU must work from its latched copy
      req_valid  = 1'b0;
      req_we     = ~we;
      req_funct3 = 3'b111;
      req_addr   = 32'hDEAD_0003;
      req_wdata  = 32'hFFFF_FFFF;
   endtask

   task automatic load_check(input string tag, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] exp);
      issue(1'b0, f3, addr, 32'h0);
      check({tag, "_c1_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "_c1_we"}, 32'(d_we), 32'd0);
      check({tag, "_c1_daddr"}, d_addr, {addr[31:2], 2'b00});
      step();
      check({tag, "_c2_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_c2_rdata"}, rsp_rdata, exp);
      check({tag, "_c2_err"}, 32'(rsp_err), 32'd0);
      step();
      check({tag, "_c3_ready"}, 32'(req_ready), 32'd1);
      check({tag, "_c3_valid"}, 32'(rsp_valid), 32'd0);
   endtask

   task automatic store_check(input string tag, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] exp_word, input logic rmw);
      int c0;
      c0 = we_cnt;
      issue(1'b1, f3, addr, wd);
      if (rmw) begin
         check({tag, "_rd_we"}, 32'(d_we), 32'd0);
         check({tag, "_rd_valid"}, 32'(rsp_valid), 32'd0);
         step();
      end
      check({tag, "_wr_we"}, 32'(d_we), 32'd1);
      check({tag, "_wr_wdata"}, d_wdata, exp_word);
      check({tag, "_wr_daddr"}, d_addr, {addr[31:2], 2'b00});
      check({tag, "_wr_valid"}, 32'(rsp_valid), 32'd0);
      step();
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_rsp_we"}, 32'(d_we), 32'd0);
      check({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
      check({tag, "_we_pulses"}, 32'(we_cnt - c0), 32'd1);
      step();
      check({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      int c0;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      rsp_ready  = 1'b1;

      // Reset state
      step();
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_valid", 32'(rsp_valid), 32'd0);
      check("rst_we", 32'(d_we), 32'd0);
      check("rst_daddr", d_addr, 32'h0);
      check("rst_dwdata", d_wdata, 32'h0);
      check("rst_rdata", rsp_rdata, 32'h0);
      check("rst_err", 32'(rsp_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Loads from the preloaded word 0x8899AABB
      load_check("lb_101", F3_B, 32'h101, 32'hFFFF_FFAA);
      load_check("lbu_101", F3_BU, 32'h101, 32'h0000_00AA);
      load_check("lh_102", F3_H, 32'h102, 32'hFFFF_8899);
      load_check("lhu_100", F3_HU, 32'h100, 32'h0000_AABB);
      load_check("lb_103", F3_B, 32'h103, 32'hFFFF_FF88);
      load_check("lw_100", F3_W, 32'h100, 32'h8899_AABB);

      // Misaligned word load
`ifdef LX32_LSU_MISALIGN_TRAP_EN
      c0 = we_cnt;
      issue(1'b0, F3_W, 32'h102, 32'h0);
      check("lw_mis_valid", 32'(rsp_valid), 32'd1);
      check("lw_mis_err", 32'(rsp_err), 32'd1);
      check("lw_mis_rdata", rsp_rdata, 32'h0);
      check("lw_mis_we", 32'(d_we), 32'd0);
      step();
      check("lw_mis_ready", 32'(req_ready), 32'd1);
      check("lw_mis_noerr", 32'(rsp_err), 32'd0);
      check("lw_mis_nowrite", 32'(we_cnt - c0), 32'd0);
`else
      load_check("lw_mis_102", F3_W, 32'h102, 32'h8899_AABB);
`endif

      // Read-modify-write halfword store, then read back
      store_check("sh_102", F3_H, 32'h102, 32'h0000_1234, 32'h1234_AABB, 1'b1);
      load_check("lw_after_sh", F3_W, 32'h100, 32'h1234_AABB);

      // Reset pulsed during WR of an SB: write and response discarded
      c0 = we_cnt;
      issue(1'b1, F3_B, 32'h100, 32'h0000_0055);
      step();
      check("sb_rst_wr_we", 32'(d_we), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("sb_rst_we_async", 32'(d_we), 32'd0);
      check("sb_rst_ready", 32'(req_ready), 32'd1);
      check("sb_rst_daddr", d_addr, 32'h0);
      check("sb_rst_dwdata", d_wdata, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("sb_rst_novalid", 32'(rsp_valid), 32'd0);
         check("sb_rst_idle", 32'(req_ready), 32'd1);
      end
      check("sb_rst_nowrite", 32'(we_cnt - c0), 32'd0);
      load_check("lw_after_rst", F3_W, 32'h100, 32'h1234_AABB);

      // Byte store into the top lane; only wdata[7:0] may be used
      store_check("sb_103", F3_B, 32'h103, 32'hFFFF_FF77, 32'h7734_AABB, 1'b1);
      load_check("lw_after_sb", F3_W, 32'h100, 32'h7734_AABB);

      // Response back-pressure with a competing request that must be ignored
      rsp_ready = 1'b0;
      issue(1'b0, F3_H, 32'h100, 32'h0);
      step();
      check("stall_first_valid", 32'(rsp_valid), 32'd1);
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = F3_W;
      req_addr   = 32'h108;
      req_wdata  = 32'h1111_1111;
      c0 = we_cnt;
      for (int i = 0; i < 5; i++) begin
         step();
         check("stall_valid", 32'(rsp_valid), 32'd1);
         check("stall_rdata", rsp_rdata, 32'hFFFF_AABB);
         check("stall_ready", 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      step();
      check("stall_release_valid", 32'(rsp_valid), 32'd0);
      check("stall_release_ready", 32'(req_ready), 32'd1);
      check("stall_nowrite", 32'(we_cnt - c0), 32'd0);
      load_check("lw_108_untouched", F3_W, 32'h108, 32'h0);

      // Back-to-back word store and load, plus unused funct3 treated as word
      store_check("sw_104", F3_W, 32'h104, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
      load_check("lw_104", F3_W, 32'h104, 32'hDEAD_BEEF);
      load_check("l011_104", 3'b011, 32'h104, 32'hDEAD_BEEF);
      load_check("l111_104", 3'b111, 32'h104, 32'hDEAD_BEEF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
